// File: rtl/controle_escrita_regs_pkg.sv
// Shared widths and writeback request type for the register-file write-port controller.
// Pure declarations: no latency, no backpressure.
package controle_escrita_regs_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int NREG   = 1 << ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [NREG-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
        return NREG'(1) << a;
    endfunction

endpackage

// File: rtl/controle_escrita_regs_arb.sv
// Two-way round-robin arbiter: combinational grant, one-cycle memory of the last winner.
// Grants are forced low while rst is high; a loser is served on the next conflict.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // 1 means requester 1 won most recently, so requester 0 wins the next conflict
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/controle_escrita_regs.sv
// Register-file write-port arbiter, one-cycle write stage and pending scoreboard; write reaches
// the register file one cycle after the grant. Optional forwarding under REG_BYPASS_EN.
module controle_escrita_regs
    import controle_escrita_regs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [ADDR_W-1:0] add_reg_write,
    output logic [DATA_W-1:0] data_reg_write,
    output logic              enable_write,
`ifdef REG_BYPASS_EN
    output logic              byp_valid1,
    output logic              byp_valid2,
    output logic [DATA_W-1:0] byp_data1,
    output logic [DATA_W-1:0] byp_data2,
`endif
    output logic [NREG-1:0]   pending
);

    wb_req_t    wb0_req;
    wb_req_t    wb1_req;
    wb_req_t    win_req;
    logic [1:0] grant;
    logic       rsv_fire;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    assign wb0_req = '{valid: wb0_valid, addr: wb0_addr, data: wb0_data};
    assign wb1_req = '{valid: wb1_valid, addr: wb1_addr, data: wb1_data};

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({wb1_valid, wb0_valid}),
        .grant (grant)
    );

    assign wb0_ready = grant[0];
    assign wb1_ready = grant[1];

    always_comb begin
        win_req = '0;
        if (grant[0]) begin
            win_req = wb0_req;
        end else if (grant[1]) begin
            win_req = wb1_req;
        end
    end

    // Address and data hold their last values when no write is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_write   <= 1'b0;
            add_reg_write  <= '0;
            data_reg_write <= '0;
        end else begin
            enable_write <= win_req.valid;
            if (win_req.valid) begin
                add_reg_write  <= win_req.addr;
                data_reg_write <= win_req.data;
            end
        end
    end

    // A pending register refuses a second reservation so a stale write cannot clear it
    assign rsv_ready = !rst && !pending[rsv_addr];
    assign rsv_fire  = rsv_valid && rsv_ready;
    assign set_mask  = rsv_fire ? reg_onehot(rsv_addr) : '0;
    assign clr_mask  = enable_write ? reg_onehot(add_reg_write) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

`ifdef REG_BYPASS_EN
    always_comb begin
        byp_valid1 = enable_write && (add_reg_write == rd_addr1);
        byp_valid2 = enable_write && (add_reg_write == rd_addr2);
        byp_data1  = byp_valid1 ? data_reg_write : '0;
        byp_data2  = byp_valid2 ? data_reg_write : '0;
        hazard1    = pending[rd_addr1] && !byp_valid1;
        hazard2    = pending[rd_addr2] && !byp_valid2;
    end
`else
    assign hazard1 = pending[rd_addr1];
    assign hazard2 = pending[rd_addr2];
`endif

endmodule

// File: tb/tb_controle_escrita_regs.sv
// Directed bench with a cycle model and write scoreboard for controle_escrita_regs.
module tb_controle_escrita_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        rsv_valid;
    logic [3:0]  rsv_addr;
    logic        rsv_ready;
    logic        wb0_valid;
    logic [3:0]  wb0_addr;
    logic [31:0] wb0_data;
    logic        wb0_ready;
    logic        wb1_valid;
    logic [3:0]  wb1_addr;
    logic [31:0] wb1_data;
    logic        wb1_ready;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic        hazard1;
    logic        hazard2;
    logic [3:0]  add_reg_write;
    logic [31:0] data_reg_write;
    logic        enable_write;
    logic [15:0] pending;
`ifdef REG_BYPASS_EN
    logic        byp_valid1;
    logic        byp_valid2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
`endif

    always #5 clk = ~clk;

    controle_escrita_regs dut (
        .clk            (clk),
        .rst            (rst),
        .rsv_valid      (rsv_valid),
        .rsv_addr       (rsv_addr),
        .rsv_ready      (rsv_ready),
        .wb0_valid      (wb0_valid),
        .wb0_addr       (wb0_addr),
        .wb0_data       (wb0_data),
        .wb0_ready      (wb0_ready),
        .wb1_valid      (wb1_valid),
        .wb1_addr       (wb1_addr),
        .wb1_data       (wb1_data),
        .wb1_ready      (wb1_ready),
        .rd_addr1       (rd_addr1),
        .rd_addr2       (rd_addr2),
        .hazard1        (hazard1),
        .hazard2        (hazard2),
        .add_reg_write  (add_reg_write),
        .data_reg_write (data_reg_write),
        .enable_write   (enable_write),
`ifdef REG_BYPASS_EN
        .byp_valid1     (byp_valid1),
        .byp_valid2     (byp_valid2),
        .byp_data1      (byp_data1),
        .byp_data2      (byp_data2),
`endif
        .pending        (pending)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    // Reference model of the write stage, scoreboard and arbiter
    logic        m_we;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    logic [15:0] m_pend;
    logic        m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_check();
        logic        e0, e1, bv1, bv2;
        logic [15:0] nxt;
        wr_t         w;
        if (rst) begin
            m_we = 1'b0; m_addr = '0; m_data = '0; m_pend = '0; m_last = 1'b1;
            wq.delete();
        end
        chk("enable_write", enable_write, m_we);
        chk("add_reg_write", add_reg_write, m_addr);
        chk("data_reg_write", data_reg_write, m_data);
        chk("pending", pending, m_pend);
        if (enable_write === 1'b1) begin
            n_cmp++;
            assert (wq.size() != 0) else begin
                n_mis++;
                $error("FAIL sb_unexpected_write: observed write r%0d, expected none", add_reg_write);
            end
            if (wq.size() != 0) begin
                w = wq.pop_front();
                chk("sb_addr", add_reg_write, w.addr);
                chk("sb_data", data_reg_write, w.data);
            end
        end
        bv1 = m_we && (m_addr == rd_addr1);
        bv2 = m_we && (m_addr == rd_addr2);
`ifdef REG_BYPASS_EN
        chk("byp_valid1", byp_valid1, bv1);
        chk("byp_valid2", byp_valid2, bv2);
        chk("byp_data1", byp_data1, bv1 ? m_data : 32'h0);
        chk("byp_data2", byp_data2, bv2 ? m_data : 32'h0);
`else
        bv1 = 1'b0;
        bv2 = 1'b0;
`endif
        chk("hazard1", hazard1, m_pend[rd_addr1] && !bv1);
        chk("hazard2", hazard2, m_pend[rd_addr2] && !bv2);
        chk("rsv_ready", rsv_ready, !rst && !m_pend[rsv_addr]);
        e0 = !rst && wb0_valid && (!wb1_valid || m_last);
        e1 = !rst && wb1_valid && (!wb0_valid || !m_last);
        chk("wb0_ready", wb0_ready, e0);
        chk("wb1_ready", wb1_ready, e1);
        if (!rst) begin
            nxt = m_pend;
            if (m_we) nxt[m_addr] = 1'b0;
            if (rsv_valid && !m_pend[rsv_addr]) nxt[rsv_addr] = 1'b1;
            m_pend = nxt;
            m_we = e0 || e1;
            if (e0) begin
                m_addr = wb0_addr; m_data = wb0_data;
                wq.push_back('{addr: wb0_addr, data: wb0_data});
            end else if (e1) begin
                m_addr = wb1_addr; m_data = wb1_data;
                wq.push_back('{addr: wb1_addr, data: wb1_data});
            end
            if (e0 || e1) m_last = e1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    initial begin
        rst = 1'b1;
        rsv_valid = 0; rsv_addr = 0;
        wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
        wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
        rd_addr1 = 0; rd_addr2 = 0;
        adv();
        step();
        rst = 1'b0;
        settle();
        chk("idle_enable_write", enable_write, 1'b0);
        chk("idle_pending", pending, 16'h0);
        adv();

        // Single ALU write to r3
        wb0_valid = 1; wb0_addr = 4'd3; wb0_data = 32'hDEADBEEF;
        settle();
        chk("t1_wb0_ready", wb0_ready, 1'b1);
        adv();
        wb0_valid = 0;
        settle();
        chk("t1_enable_write", enable_write, 1'b1);
        chk("t1_addr", add_reg_write, 4'd3);
        chk("t1_data", data_reg_write, 32'hDEADBEEF);
        adv();
        step();

        // Reserve r5, then load writes it; hazard1 watches r5
        rd_addr1 = 4'd5; rsv_valid = 1; rsv_addr = 4'd5;
        step();
        rsv_valid = 0;
        settle();
        chk("t2_hazard_reserved", hazard1, 1'b1);
        adv();
        wb1_valid = 1; wb1_addr = 4'd5; wb1_data = 32'h12345678;
        settle();
        chk("t2_wb1_ready", wb1_ready, 1'b1);
        chk("t2_hazard_edgeN", hazard1, 1'b1);
        adv();
        wb1_valid = 0;
        settle();
        chk("t2_enable_write", enable_write, 1'b1);
`ifdef REG_BYPASS_EN
        chk("t2_hazard_N1_byp", hazard1, 1'b0);
`else
        chk("t2_hazard_N1", hazard1, 1'b1);
`endif
        adv();
        settle();
        chk("t2_hazard_N2", hazard1, 1'b0);
        chk("t2_pending5", pending[5], 1'b0);
        adv();

        // Sustained conflict for four cycles
        wb0_valid = 1; wb0_addr = 4'd1; wb0_data = 32'hA000_0000;
        wb1_valid = 1; wb1_addr = 4'd2; wb1_data = 32'hB000_0000;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t3_wb0_ready", wb0_ready, (i % 2) == 0);
            chk("t3_wb1_ready", wb1_ready, (i % 2) == 1);
            adv();
            if ((i % 2) == 0) wb0_data = wb0_data + 1;
            else              wb1_data = wb1_data + 1;
        end
        wb0_valid = 0; wb1_valid = 0;
        step();
        step();

        // Double reservation refused; reservation on the commit edge survives
        rsv_valid = 1; rsv_addr = 4'd7;
        step();
        settle();
        chk("t4_rsv_refused", rsv_ready, 1'b0);
        adv();
        rsv_valid = 0;
        wb0_valid = 1; wb0_addr = 4'd7; wb0_data = 32'h7777_0001;
        step();
        wb0_valid = 0;
        step();
        settle();
        chk("t4_pending7_cleared", pending[7], 1'b0);
        adv();
        wb0_valid = 1; wb0_data = 32'h7777_0002;
        step();
        wb0_valid = 0; rsv_valid = 1;
        settle();
        chk("t4_commit_rsv_ready", rsv_ready, 1'b1);
        chk("t4_commit_we", enable_write, 1'b1);
        adv();
        rsv_valid = 0;
        settle();
        chk("t4_set_wins", pending[7], 1'b1);
        adv();

`ifdef REG_BYPASS_EN
        // Forwarding of r9 during its write cycle
        rsv_valid = 1; rsv_addr = 4'd9; rd_addr2 = 4'd9;
        step();
        rsv_valid = 0;
        wb0_valid = 1; wb0_addr = 4'd9; wb0_data = 32'hA5A5A5A5;
        step();
        wb0_valid = 0;
        settle();
        chk("t5_byp_valid2", byp_valid2, 1'b1);
        chk("t5_byp_data2", byp_data2, 32'hA5A5A5A5);
        chk("t5_hazard2", hazard2, 1'b0);
        adv();
        step();
`endif

        // Reset while a write is registered and r2 is pending
        rsv_valid = 1; rsv_addr = 4'd2;
        step();
        rsv_valid = 0;
        wb0_valid = 1; wb0_addr = 4'd4; wb0_data = 32'h0BAD_F00D;
        step();
        wb0_valid = 0;
        rst = 1'b1;
        settle();
        chk("t6_rst_enable_write", enable_write, 1'b0);
        chk("t6_rst_pending", pending, 16'h0);
        chk("t6_rst_wb0_ready", wb0_ready, 1'b0);
        adv();
        rst = 1'b0;
        step();
        step();

        n_cmp++;
        assert (wq.size() == 0) else begin
            n_mis++;
            $error("FAIL sb_leftover: observed %0d queued writes, expected 0", wq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/controle_escrita_regs.md
# controle_escrita_regs

Write-port controller and scoreboard for the 16 x 32-bit register file. Shares the register file's single write port between the ALU writeback path and the load path with round-robin arbitration, registers the winning write for one cycle, and drives the register file's `add_reg_write`, `data_reg_write` and `enable_write`. A per-register pending bitmap lets decode reserve destination registers and detect read-after-write hazards.

## Interface
- `ADDR_W`, 4: register address width
- `DATA_W`, 32: data width
- `NREG`, 16: register count (2^ADDR_W)

- `clk` in 1: clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `rsv_valid` in 1: decode reserves a destination register
- `rsv_addr` in ADDR_W: register to reserve
- `rsv_ready` out 1: reservation accepted; equals `!pending[rsv_addr]`
- `wb0_valid` in 1: ALU writeback request
- `wb0_addr` in ADDR_W, `wb0_data` in DATA_W
- `wb0_ready` out 1: wb0 granted this cycle
- `wb1_valid` in 1: load writeback request
- `wb1_addr` in ADDR_W, `wb1_data` in DATA_W
- `wb1_ready` out 1: wb1 granted this cycle
- `rd_addr1`, `rd_addr2` in ADDR_W: decode read addresses
- `hazard1`, `hazard2` out 1: operand not yet available
- `add_reg_write` out ADDR_W, `data_reg_write` out DATA_W, `enable_write` out 1: to register file
- `pending` out NREG: scoreboard bitmap

## Operation
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. The requester holds valid, addr and data stable until ready. Ready is combinational from the valids and the arbiter state.
- Arbiter: at most one grant per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester not in `last_grant` is granted.
  - `last_grant` updates on every grant. Reset value is 1, so wb0 wins the first conflict.
- Write stage: a granted request is registered. The next cycle has `enable_write`=1 with that addr and data. With no grant, `enable_write`=0 and addr/data hold their last values.
- Scoreboard, at each rising edge:
  - `rsv_valid && rsv_ready` sets `pending[rsv_addr]`.
  - `enable_write` clears `pending[add_reg_write]`.
  - Set and clear on the same address: set wins.
  - Clearing a bit that is not set is a no-op; the write still happens.
- Reserving a register that is already pending is refused (`rsv_ready`=0). This prevents an early write from clearing a later reservation.
- Register 0 is an ordinary register, with no special case.
- `hazardN` = `pending[rd_addrN]`, combinational.
- Reset: `enable_write`=0, `add_reg_write`=0, `data_reg_write`=0, `pending`=0, `last_grant`=1. While `rst` is high, `wb0_ready`, `wb1_ready` and `rsv_ready` are forced to 0. Reset mid-operation discards any registered write and all reservations.

## Timing
- Handshake edge N → `enable_write` high in cycle N+1 → register file updated at edge N+2.
- From edge N+2, the combinational register file read returns the new value and the pending bit is clear.
- Without bypass, `hazard` stays 1 through cycle N+1.
- Throughput: one write per cycle. A losing requester waits at least one cycle.
- Sustained conflict: grants alternate wb0, wb1, wb0, …

## Configuration
- `REG_BYPASS_EN` defined:
  - Adds outputs `byp_valid1`/`byp_valid2` (1 bit) and `byp_data1`/`byp_data2` (DATA_W).
  - When `enable_write` is 1 and `add_reg_write == rd_addrN`: `byp_validN`=1, `byp_dataN`=`data_reg_write`, `hazardN`=0, saving one stall cycle.
  - Otherwise `byp_validN`=0 and `byp_dataN`=0.
- `REG_BYPASS_EN` undefined: these ports do not exist, and `hazardN` is the raw pending bit.

## Structure
- Shared package holds: `ADDR_W`, `DATA_W`, `NREG` constants, and a `wb_req_t` typedef (valid, addr, data).
- Sub-module `rr_arbiter2`: two-way round-robin with `req[1:0]`, `grant[1:0]` and an internal `last_grant` flop.
- Write stage, scoreboard and bypass logic live in the top module.

## Test plan
- Reset then idle → all outputs 0, `pending`=0; a single wb0 write (addr 3, data 0xDEADBEEF) → `enable_write`=1 next cycle with addr 3 and that data.
- Reserve r5, then wb1 writes r5=0x12345678 → `hazard1` (rd_addr1=5) stays 1 until edge N+2, then 0 and `pending[5]`=0.
- wb0 and wb1 both valid for 4 cycles → grants wb0, wb1, wb0, wb1; each ready only in its grant cycle; data held while stalled.
- Reserve r7 with r7 pending → `rsv_ready`=0. Reserve r7 on the same edge as r7's commit → `pending[7]` remains 1.
- With `REG_BYPASS_EN`, rd_addr2=9 during r9's write cycle (data 0xA5A5A5A5) → `byp_valid2`=1, `byp_data2`=0xA5A5A5A5, `hazard2`=0.
- Assert `rst` while a write is registered and r2 is pending → `enable_write`=0 and `pending`=0 immediately; the register file sees no write.
